// File: rtl/sram_slave_port_pkg.sv
// sram_slave_port_pkg
//   Shared interconnect helpers for the slave-port endpoint.
//   - be_width()    : number of byte lanes for a given data width
//   - byte_offset() : number of byte-address bits below the word address
//   - track_t       : one entry of the response tracking pipeline
package sram_slave_port_pkg;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int byte_offset(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // One in-flight transaction as seen by the tracking pipeline.
  typedef struct packed {
    logic valid;
    logic we;
  } track_t;

endpackage

// File: rtl/sram_slave_port_resp_pipe.sv
// sram_slave_port_resp_pipe
//   Fixed-depth {valid, we} shift register. It advances every cycle with
//   no stall, so an entry loaded in cycle T appears at the output in
//   cycle T+DEPTH. Reusable for any fixed-latency slave.
// Ports:
//   clk       : rising-edge clock
//   resetn    : asynchronous active-low reset, clears every stage
//   entry_in  : entry captured into stage 0 each cycle
//   entry_out : contents of the last stage
module sram_slave_port_resp_pipe
  import sram_slave_port_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   resetn,
  input  track_t entry_in,
  output track_t entry_out
);

  track_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= entry_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign entry_out = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_slave_port.sv
// sram_slave_port
//   Slave-side endpoint between one interconnect slave port and an SRAM
//   bank with a fixed read latency. Requests are accepted combinationally,
//   the SRAM command is issued in the accept cycle, and one response
//   (rvalid, rdata) per accepted transaction returns in acceptance order
//   SRAM_LATENCY+1 cycles later. Writes respond with rdata = 0.
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   slave_data_*_i        : request side (addr, wdata, be, req, we)
//   slave_data_gnt_o      : request accepted this cycle
//   slave_data_rvalid_o   : one-cycle response strobe
//   slave_data_rdata_o    : response data (0 for writes)
//   sram_*_o              : SRAM command (cs, we, word addr, wdata, be)
//   sram_gnt_i            : SRAM available this cycle
//   sram_rdata_i          : SRAM read data, SRAM_LATENCY after command
//   idle_o                : no transaction in flight
// Handshake: a transaction transfers in any cycle where req and gnt are
//   both high; the master holds req and its payload until then. rvalid is
//   a pure strobe with no back-pressure: the master must always accept it.
module sram_slave_port
  import sram_slave_port_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int SRAM_LATENCY    = 1,
  parameter int WORD_ADDR_WIDTH = ADDR_WIDTH - $clog2(DATA_WIDTH/8)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [ADDR_WIDTH-1:0]      slave_data_addr_i,
  input  logic [DATA_WIDTH-1:0]      slave_data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]    slave_data_be_i,
  input  logic                       slave_data_req_i,
  input  logic                       slave_data_we_i,
  output logic                       slave_data_gnt_o,
  output logic                       slave_data_rvalid_o,
  output logic [DATA_WIDTH-1:0]      slave_data_rdata_o,
  output logic                       sram_cs_o,
  output logic                       sram_we_o,
  output logic [WORD_ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]      sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]    sram_be_o,
  input  logic                       sram_gnt_i,
  input  logic [DATA_WIDTH-1:0]      sram_rdata_i,
  output logic                       idle_o
);

  localparam int BE_WIDTH    = be_width(DATA_WIDTH);
  localparam int BYTE_OFFSET = byte_offset(DATA_WIDTH);
  localparam int CNT_W       = $clog2(SRAM_LATENCY + 2);

  logic                  resetn_q;
  logic                  gnt;
  track_t                pipe_in;
  track_t                pipe_out;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      count_q;

  // Blocks grants until the first edge after reset release, so a request
  // held high across reset is never accepted in the release cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resetn_q <= 1'b0;
    end else begin
      resetn_q <= 1'b1;
    end
  end

  assign gnt              = slave_data_req_i & sram_gnt_i & resetn_q;
  assign slave_data_gnt_o = gnt;

  // Command path: everything is zeroed when nothing is granted so the
  // SRAM pins are quiet on idle cycles.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (gnt) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = slave_data_we_i;
      sram_addr_o  = slave_data_addr_i[ADDR_WIDTH-1:BYTE_OFFSET];
      sram_wdata_o = slave_data_wdata_i;
      sram_be_o    = slave_data_be_i;
    end
  end

  // Byte-offset address bits select nothing inside a word.
  generate
    if (BYTE_OFFSET > 0) begin : g_low_bits
      logic unused_low_addr;
      assign unused_low_addr = ^slave_data_addr_i[BYTE_OFFSET-1:0];
    end
  endgenerate

  assign pipe_in.valid = gnt;
  assign pipe_in.we    = slave_data_we_i;

  sram_slave_port_resp_pipe #(
    .DEPTH (SRAM_LATENCY)
  ) u_resp_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .entry_in  (pipe_in),
    .entry_out (pipe_out)
  );

  // The last pipeline stage lines up with valid sram_rdata_i; capture it.
  // rdata holds its value between responses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pipe_out.valid;
      if (pipe_out.valid) begin
        rdata_q <= pipe_out.we ? '0 : sram_rdata_i;
      end
    end
  end

  assign slave_data_rvalid_o = rvalid_q;
  assign slave_data_rdata_o  = rdata_q;

  // Counts transactions between grant and response. Bounded by the
  // pipeline depth plus the response register, i.e. SRAM_LATENCY+1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      unique case ({gnt, rvalid_q})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign idle_o = (count_q == '0);

endmodule

// File: doc/sram_slave_port.md
# sram_slave_port

Slave-side endpoint for one interconnect slave port. It accepts req/gnt transactions and drives a synchronous SRAM macro with a fixed read latency. It returns in-order rvalid/rdata responses for both reads and writes. One instance sits on each `slave_data_*` port of the interconnect, between the interconnect and a memory bank.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `ADDR_WIDTH`, 10: byte address width received from the interconnect.
- `SRAM_LATENCY`, 1: cycles from the SRAM command to valid `sram_rdata_i`. Legal range is 1..4.
- `WORD_ADDR_WIDTH`, `ADDR_WIDTH - $clog2(DATA_WIDTH/8)`: SRAM word address width.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `slave_data_addr_i` in ADDR_WIDTH: byte address. Low `$clog2(DATA_WIDTH/8)` bits are ignored.
- `slave_data_wdata_i` in DATA_WIDTH: write data.
- `slave_data_be_i` in DATA_WIDTH/8: byte enables.
- `slave_data_req_i` in 1: request valid.
- `slave_data_we_i` in 1: 1 = write, 0 = read.
- `slave_data_gnt_o` out 1: request accepted this cycle.
- `slave_data_rvalid_o` out 1: response valid for one cycle.
- `slave_data_rdata_o` out DATA_WIDTH: read data; 0 on write responses.
- `sram_cs_o` out 1: SRAM chip select.
- `sram_we_o` out 1: SRAM write enable.
- `sram_addr_o` out WORD_ADDR_WIDTH: SRAM word address.
- `sram_wdata_o` out DATA_WIDTH: SRAM write data.
- `sram_be_o` out DATA_WIDTH/8: SRAM byte write mask.
- `sram_gnt_i` in 1: SRAM available this cycle. 0 during BIST or external access.
- `sram_rdata_i` in DATA_WIDTH: SRAM read data.
- `idle_o` out 1: no transaction in flight.

## Operation
- **Accept:** `slave_data_gnt_o = slave_data_req_i & sram_gnt_i & resetn_q`. `resetn_q` is the internal reset flop, cleared asynchronously and set on the first clock edge after `resetn` rises. This path is combinational.
- **SRAM command:** the command is issued in the accept cycle, combinationally.
  - `sram_cs_o = gnt`, `sram_we_o = gnt & we`.
  - `sram_addr_o = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]`.
  - `sram_wdata_o` and `sram_be_o` pass through unmodified.
  - When there is no grant: `sram_cs_o = 0`, `sram_we_o = 0`, and address, data and mask are forced to 0.
- **Tracking pipeline:** SRAM_LATENCY stages, each holding {valid, we}. Stage 0 loads {gnt, we} each cycle and later stages shift by one. There is no stall: the pipeline advances every cycle.
- **Response register:** loaded when the last stage is valid.
  - On the following edge, `slave_data_rvalid_o` ← 1.
  - `slave_data_rdata_o` ← `sram_rdata_i` for reads, 0 for writes.
  - When no stage completes, `rvalid_o` ← 0 and `rdata_o` keeps its previous value.
- **In-flight counter:** width `$clog2(SRAM_LATENCY+2)`.
  - Increments on grant and decrements on response.
  - A simultaneous grant and response leaves it unchanged.
  - It never exceeds SRAM_LATENCY+1.
  - `idle_o = (count == 0)`.
- **Throughput:** one transaction per cycle sustained; there is no outstanding limit beyond the pipeline depth.
- **Ordering:** responses are strictly in acceptance order.

## Timing
- Response latency: a request granted in cycle T gets `slave_data_rvalid_o` high in cycle T+SRAM_LATENCY+1, for exactly one cycle.
- Back-to-back grants give back-to-back rvalids.
- **Reset:** `resetn` low clears all pipeline stages, the counter, `rvalid_o`, `rdata_o` (to 0) and `resetn_q`. The outputs are then:
  - `gnt_o = 0`
  - `sram_cs_o = 0`
  - `sram_we_o = 0`
  - `idle_o = 1`
- **Reset mid-operation:** in-flight responses are dropped. No rvalid is produced for any transaction granted before reset. The first grant is possible one cycle after `resetn` deasserts.
- **`sram_gnt_i` low:** `gnt_o = 0`. The request is held by the master and is not queued. In-flight responses still complete on schedule.
- **Simultaneous write then read to the same address** (cycles T, T+1): the read returns the new data. This relies on SRAM write-first ordering; the block adds no forwarding.

## Structure
- Shared interconnect package: the bus field-width helpers (`BE_WIDTH = DATA_WIDTH/8`, `BYTE_OFFSET = $clog2(BE_WIDTH)`).
- Natural sub-module: `resp_pipe`. It is a parameterised {valid, we} shift register of depth SRAM_LATENCY with async reset, and can be reused for other fixed-latency slaves.
- Counter, response register and command path stay in the top module.

## Test plan
- **Single read:** SRAM_LATENCY=1, preload word 3 = 0xDEADBEEF, read addr 0x00C at T → `sram_cs_o`=1 at T, `sram_addr_o`=3; `rvalid_o`=1 at T+2 with `rdata_o`=0xDEADBEEF.
- **Write then read:** write 0x12345678, be=4'b0011, to addr 0x010, then read it → `sram_be_o`=0011; write rvalid with rdata=0; the read returns the low half updated.
- **Streaming:** SRAM_LATENCY=3, 8 back-to-back reads → 8 consecutive rvalid cycles starting at T+4, data in order; `idle_o` low throughout, high one cycle after the last rvalid.
- **SRAM busy:** `sram_gnt_i`=0 for 3 cycles while req is high → `gnt_o`=0, `sram_cs_o`=0 for those cycles; grant is issued the cycle `sram_gnt_i` returns; counter stays consistent.
- **Reset mid-flight:** SRAM_LATENCY=4, 2 reads in flight, pulse `resetn` low asynchronously mid-cycle → outputs clear immediately, no rvalid afterwards, `idle_o`=1, first new grant one cycle after release.
- **Low-bit masking:** read addr 0x00F → `sram_addr_o`=3, identical to a read at 0x00C.
